// File: rtl/axi_4_lite_mem_slave_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite memory responder.
package axi_4_lite_mem_slave_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      WR_IDLE,
      WR_WDATA,
      WR_WADDR,
      WR_COMMIT,
      WR_RESP
   } wr_state_e;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_WAIT,
      RD_RESP
   } rd_state_e;

endpackage

// File: rtl/axi_4_lite_mem_slave_ram.sv
// Word array with byte-lane strobed synchronous write and combinational read.
// The read port sees pre-write contents in the same cycle as a write (read-before-write).
module mem_bytewrite_ram #(
   parameter int DATA_W    = 64,
   parameter int MEM_DEPTH = 1024,
   parameter int IDX_W     = 10
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [IDX_W-1:0]    waddr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   input  logic [IDX_W-1:0]    raddr_i,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_4_lite_mem_slave.sv
// AXI4-Lite responder over a strobed 64-bit memory; independent write and read FSMs,
// configurable read latency, DECERR for addresses outside the mapped window.
module axi_4_lite_mem_slave
   import axi_4_lite_mem_slave_pkg::*;
#(
   parameter int               ADDR_W     = 32,
   parameter int               DATA_W     = 64,
   parameter int               MEM_DEPTH  = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int               RD_LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
   input  logic [2:0]          S_AXI_AWPROT,
   input  logic                S_AXI_AWVALID,
   output logic                S_AXI_AWREADY,
   input  logic [DATA_W-1:0]   S_AXI_WDATA,
   input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
   input  logic                S_AXI_WVALID,
   output logic                S_AXI_WREADY,
   output logic [1:0]          S_AXI_BRESP,
   output logic                S_AXI_BVALID,
   input  logic                S_AXI_BREADY,
   input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
   input  logic [2:0]          S_AXI_ARPROT,
   input  logic                S_AXI_ARVALID,
   output logic                S_AXI_ARREADY,
   output logic [DATA_W-1:0]   S_AXI_RDATA,
   output logic [1:0]          S_AXI_RRESP,
   output logic                S_AXI_RVALID,
   input  logic                S_AXI_RREADY
);

   localparam int              IDX_W     = $clog2(MEM_DEPTH);
   localparam int              STRB_W    = DATA_W/8;
   localparam int              CNT_W     = 4;
   localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(8*MEM_DEPTH);

   // Unsigned compare on a widened offset so addresses below BASE_ADDR never alias in.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] off;
      off = {1'b0, a} - {1'b0, BASE_ADDR};
      return (a >= BASE_ADDR) && (off < WIN_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> 3);
   endfunction

   wr_state_e           wr_state_q, wr_state_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [1:0]          bresp_q, bresp_d;
   logic                awready, wready, mem_we;

   rd_state_e           rd_state_q, rd_state_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic                arready;
   logic [DATA_W-1:0]   ram_rdata;

   logic                unused_prot;
   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   always_comb begin
      wr_state_d = wr_state_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      awready    = 1'b0;
      wready     = 1'b0;
      mem_we     = 1'b0;
      unique case (wr_state_q)
         WR_IDLE: begin
            awready = 1'b1;
            wready  = 1'b1;
            if (S_AXI_AWVALID) awaddr_d = S_AXI_AWADDR;
            if (S_AXI_WVALID) begin
               wdata_d = S_AXI_WDATA;
               wstrb_d = S_AXI_WSTRB;
            end
            if (S_AXI_AWVALID && S_AXI_WVALID) wr_state_d = WR_COMMIT;
            else if (S_AXI_AWVALID)            wr_state_d = WR_WDATA;
            else if (S_AXI_WVALID)             wr_state_d = WR_WADDR;
         end
         WR_WDATA: begin
            wready = 1'b1;
            if (S_AXI_WVALID) begin
               wdata_d    = S_AXI_WDATA;
               wstrb_d    = S_AXI_WSTRB;
               wr_state_d = WR_COMMIT;
            end
         end
         WR_WADDR: begin
            awready = 1'b1;
            if (S_AXI_AWVALID) begin
               awaddr_d   = S_AXI_AWADDR;
               wr_state_d = WR_COMMIT;
            end
         end
         WR_COMMIT: begin
            // A reset landing on the commit cycle must not let the write through.
            mem_we     = in_range(awaddr_q) && !rst;
            bresp_d    = in_range(awaddr_q) ? RESP_OKAY : RESP_DECERR;
            wr_state_d = WR_RESP;
         end
         WR_RESP: begin
            if (S_AXI_BREADY) wr_state_d = WR_IDLE;
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      araddr_d   = araddr_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      arready    = 1'b0;
      unique case (rd_state_q)
         RD_IDLE: begin
            arready = 1'b1;
            if (S_AXI_ARVALID) begin
               araddr_d   = S_AXI_ARADDR;
               cnt_d      = CNT_W'(RD_LATENCY - 1);
               rd_state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               rdata_d    = in_range(araddr_q) ? ram_rdata : '0;
               rresp_d    = in_range(araddr_q) ? RESP_OKAY : RESP_DECERR;
               rd_state_d = RD_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RD_RESP: begin
            if (S_AXI_RREADY) rd_state_d = RD_IDLE;
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q <= WR_IDLE;
         bresp_q    <= RESP_OKAY;
         rd_state_q <= RD_IDLE;
         cnt_q      <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         bresp_q    <= bresp_d;
         rd_state_q <= rd_state_d;
         cnt_q      <= cnt_d;
         rresp_q    <= rresp_d;
      end
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      araddr_q <= araddr_d;
      rdata_q  <= rdata_d;
   end

   mem_bytewrite_ram #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH),
      .IDX_W     (IDX_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (word_idx(awaddr_q)),
      .wdata_i (wdata_q),
      .wstrb_i (wstrb_q),
      .raddr_i (word_idx(araddr_q)),
      .rdata_o (ram_rdata)
   );

   // Outputs are forced to their idle values for as long as rst is held.
   assign S_AXI_AWREADY = awready && !rst;
   assign S_AXI_WREADY  = wready && !rst;
   assign S_AXI_ARREADY = arready && !rst;
   assign S_AXI_BVALID  = (wr_state_q == WR_RESP) && !rst;
   assign S_AXI_BRESP   = rst ? RESP_OKAY : bresp_q;
   assign S_AXI_RVALID  = (rd_state_q == RD_RESP) && !rst;
   assign S_AXI_RRESP   = rst ? RESP_OKAY : rresp_q;
   assign S_AXI_RDATA   = rst ? '0 : rdata_q;

endmodule

// File: tb/tb_axi_4_lite_mem_slave.sv
// Directed bench for the AXI4-Lite memory responder with response scoreboards.
module tb_axi_4_lite_mem_slave;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [63:0] rdata;

   logic [31:0] araddr4;
   logic        arvalid4;
   logic        awready4, wready4, bvalid4, arready4, rvalid4;
   logic [1:0]  bresp4, rresp4;
   logic [63:0] rdata4;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [63:0] d;
      logic [1:0]  r;
   } rexp_t;
   rexp_t       rq[$];
   logic [1:0]  bq[$];

   axi_4_lite_mem_slave dut (
      .clk(clk), .rst(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
   );

   axi_4_lite_mem_slave #(.RD_LATENCY(4)) dut_l4 (
      .clk(clk), .rst(rst),
      .S_AXI_AWADDR(32'h0), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(1'b0), .S_AXI_AWREADY(awready4),
      .S_AXI_WDATA(64'h0), .S_AXI_WSTRB(8'h00), .S_AXI_WVALID(1'b0), .S_AXI_WREADY(wready4),
      .S_AXI_BRESP(bresp4), .S_AXI_BVALID(bvalid4), .S_AXI_BREADY(1'b1),
      .S_AXI_ARADDR(araddr4), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid4), .S_AXI_ARREADY(arready4),
      .S_AXI_RDATA(rdata4), .S_AXI_RRESP(rresp4), .S_AXI_RVALID(rvalid4), .S_AXI_RREADY(1'b1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Waits for BVALID, optionally holds BREADY low for 'hold' cycles, then completes B.
   task automatic get_b(input string tag, input int exp_lat, input int hold);
      int n;
      logic [1:0] e;
      n = 0;
      while (!bvalid && n < 20) begin tick(); n++; end
      if (exp_lat >= 0) chk({tag, "_blat"}, 64'(n), 64'(exp_lat));
      e = bq.pop_front();
      for (int i = 0; i < hold; i++) begin
         chk({tag, "_bhold_valid"}, 64'(bvalid), 64'd1);
         chk({tag, "_bhold_resp"}, 64'(bresp), 64'(e));
         chk({tag, "_bhold_awready"}, 64'(awready), 64'd0);
         tick();
      end
      bready = 1'b1;
      chk({tag, "_bresp"}, 64'(bresp), 64'(e));
      tick();
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [63:0] d,
                     input logic [7:0] s, input logic [1:0] er, input int hold);
      int n;
      bq.push_back(er);
      bready  = (hold == 0);
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      n = 0;
      while (!(awready && wready) && n < 20) begin tick(); n++; end
      if (n >= 20) chk({tag, "_aw_timeout"}, 64'd1, 64'd0);
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      get_b(tag, 1, hold);
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [63:0] ed,
                     input logic [1:0] er, input int hold);
      int n;
      rexp_t x, e;
      x.d = ed;
      x.r = er;
      rq.push_back(x);
      rready  = (hold == 0);
      araddr  = a;
      arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin tick(); n++; end
      if (n >= 20) chk({tag, "_ar_timeout"}, 64'd1, 64'd0);
      tick();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 40) begin tick(); n++; end
      chk({tag, "_rlat"}, 64'(n), 64'd1);
      e = rq.pop_front();
      for (int i = 0; i < hold; i++) begin
         chk({tag, "_rhold_valid"}, 64'(rvalid), 64'd1);
         chk({tag, "_rhold_data"}, rdata, e.d);
         chk({tag, "_rhold_arready"}, 64'(arready), 64'd0);
         tick();
      end
      rready = 1'b1;
      chk({tag, "_rdata"}, rdata, e.d);
      chk({tag, "_rresp"}, 64'(rresp), 64'(e.r));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rexp_t e;
      logic [1:0] eb;

      rst = 1'b1;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
      araddr4 = 0; arvalid4 = 0;
      repeat (3) tick();
      chk("rst_awready", 64'(awready), 64'd0);
      chk("rst_wready", 64'(wready), 64'd0);
      chk("rst_arready", 64'(arready), 64'd0);
      chk("rst_valids", 64'({bvalid, rvalid}), 64'd0);
      chk("rst_resps", 64'({bresp, rresp}), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_readys", 64'({awready, wready, arready}), 64'b111);

      // Aligned full-word write and read-back.
      wr("full_wr", 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 2'b00, 0);
      chk("b_done_awready", 64'(awready), 64'd1);
      rd("full_rd", 32'h8000_0008, 64'h1122_3344_5566_7788, 2'b00, 0);
      chk("r_done_arready", 64'(arready), 64'd1);

      // Single-lane strobe into an all-ones word.
      wr("ones_wr", 32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 0);
      wr("lane2_wr", 32'h8000_0010, 64'h0, 8'h04, 2'b00, 0);
      rd("lane2_rd", 32'h8000_0010, 64'hFFFF_FFFF_FF00_FFFF, 2'b00, 0);

      // Empty strobe: OKAY and no change.
      wr("strb0_wr", 32'h8000_0008, 64'h0, 8'h00, 2'b00, 0);
      rd("strb0_rd", 32'h8000_0008, 64'h1122_3344_5566_7788, 2'b00, 0);

      // W three cycles ahead of AW.
      bq.push_back(2'b00);
      wdata = 64'hA5A5_0000_1234_5678; wstrb = 8'hFF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("wfirst_wready", 64'(wready), 64'd0);
      chk("wfirst_awready", 64'(awready), 64'd1);
      repeat (3) tick();
      chk("wfirst_no_b", 64'(bvalid), 64'd0);
      awaddr = 32'h8000_0018; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      get_b("wfirst", 1, 0);
      rd("wfirst_rd", 32'h8000_0018, 64'hA5A5_0000_1234_5678, 2'b00, 0);

      // AW three cycles ahead of W.
      bq.push_back(2'b00);
      awaddr = 32'h8000_0038; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("awfirst_awready", 64'(awready), 64'd0);
      chk("awfirst_wready", 64'(wready), 64'd1);
      repeat (3) tick();
      chk("awfirst_no_b", 64'(bvalid), 64'd0);
      wdata = 64'h0F0F_F0F0_0000_9999; wstrb = 8'hFF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      get_b("awfirst", 1, 0);
      rd("awfirst_rd", 32'h8000_0038, 64'h0F0F_F0F0_0000_9999, 2'b00, 0);

      // Out-of-range accesses; 0x1000 aliases the index of 0x8000_1000 if undecoded.
      wr("alias_pre", 32'h8000_1000, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 2'b00, 0);
      wr("oor_wr", 32'h0000_1000, 64'h0, 8'hFF, 2'b11, 0);
      rd("oor_rd", 32'h0000_1000, 64'h0, 2'b11, 0);
      rd("alias_rd", 32'h8000_1000, 64'hCAFE_F00D_DEAD_BEEF, 2'b00, 0);

      // Window edges.
      wr("last_wr", 32'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 0);
      rd("last_rd", 32'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 2'b00, 0);
      rd("end_rd", 32'h8000_2000, 64'h0, 2'b11, 0);
      wr("below_wr", 32'h7FFF_FFF8, 64'h0, 8'hFF, 2'b11, 0);
      rd("below_chk", 32'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 2'b00, 0);

      // Backpressure on both response channels.
      rd("rbp", 32'h8000_0018, 64'hA5A5_0000_1234_5678, 2'b00, 5);
      wr("bbp", 32'h8000_0040, 64'h5555_6666_7777_8888, 8'hFF, 2'b00, 5);
      rd("bbp_rd", 32'h8000_0040, 64'h5555_6666_7777_8888, 2'b00, 0);

      // Read sample and write commit to one word in the same cycle.
      wr("rbw_pre", 32'h8000_0020, 64'h1111_1111_1111_1111, 8'hFF, 2'b00, 0);
      e.d = 64'h1111_1111_1111_1111;
      e.r = 2'b00;
      rq.push_back(e);
      bq.push_back(2'b00);
      bready = 1'b1; rready = 1'b1;
      araddr = 32'h8000_0020; arvalid = 1'b1;
      awaddr = 32'h8000_0020; wdata = 64'h2222_2222_2222_2222; wstrb = 8'hFF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      tick();
      e = rq.pop_front();
      eb = bq.pop_front();
      chk("rbw_valids", 64'({rvalid, bvalid}), 64'b11);
      chk("rbw_rdata", rdata, e.d);
      chk("rbw_bresp", 64'(bresp), 64'(eb));
      tick();
      rd("rbw_after", 32'h8000_0020, 64'h2222_2222_2222_2222, 2'b00, 0);

      // Reset between AW and W abandons the write.
      wr("rstw_pre", 32'h8000_0028, 64'h3333_4444_5555_6666, 8'hFF, 2'b00, 0);
      awaddr = 32'h8000_0028; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("rstw_in_wdata", 64'({awready, wready}), 64'b01);
      rst = 1'b1;
      tick();
      chk("rstw_readys", 64'({awready, wready, arready}), 64'b000);
      chk("rstw_valids", 64'({bvalid, rvalid}), 64'b00);
      chk("rstw_rdata", rdata, 64'h0);
      rst = 1'b0;
      #1;
      chk("rstw_idle", 64'({awready, wready}), 64'b11);
      tick();
      rd("rstw_rd", 32'h8000_0028, 64'h3333_4444_5555_6666, 2'b00, 0);
      wr("rstw_next", 32'h8000_0030, 64'h7777_8888_9999_AAAA, 8'hFF, 2'b00, 0);
      rd("rstw_next_rd", 32'h8000_0030, 64'h7777_8888_9999_AAAA, 2'b00, 0);

      // Four-cycle read latency instance.
      araddr4 = 32'h0000_1000; arvalid4 = 1'b1;
      n = 0;
      while (!arready4 && n < 20) begin tick(); n++; end
      tick();
      arvalid4 = 1'b0;
      n = 0;
      while (!rvalid4 && n < 40) begin tick(); n++; end
      chk("lat4_rlat", 64'(n), 64'd4);
      chk("lat4_rresp", 64'(rresp4), 64'b11);
      chk("lat4_rdata", rdata4, 64'h0);
      tick();
      chk("lat4_idle", 64'({rvalid4, arready4}), 64'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
